pwm_ramp_sequencer: RTL and testbench
=====================================

Name: pwm_ramp_sequencer

Overview:
- Slew-rate-limited command sequencer that drives the signed 6-bit duty input of the signed PWM generator.
- Accepts signed duty targets over a valid/ready handshake and steps `dutyOut` by ±1 at PWM period boundaries only.
- Inserts a zero-duty dwell on every direction reversal and provides emergency stop and enable-based ramp-down.
- Sits between the motor/control logic and the PWM block; shares CLK/RESET with it so the period counters stay aligned.

Parameters:
- PERIOD_CYCLES, 1500, clocks per PWM period; must equal the PWM block's period (15 units × 100).
- STEP_PERIODS, 4, PWM periods between successive ±1 duty steps; minimum 1.
- ZERO_DWELL, 2, PWM periods `dutyOut` is held at 0 before crossing sign; 0 means no dwell.
- MAX_MAG, 15, magnitude clamp for targets; range 1..15.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- tgtValid  in  1  target offer
- tgtReady  out  1  sequencer can accept a target
- tgtValue  in  6  signed target duty, two's complement
- enable  in  1  0 means ramp to zero; stored target is retained
- estop  in  1  emergency stop, level sensitive
- dutyOut  out  6  signed duty command to the PWM block
- periodTick  out  1  one-cycle pulse on the last clock of each PWM period
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Interface: one clock, CLK. Reset RESET is synchronous and active-high.
- Reset values: `dutyOut`=0, `periodTick`=0, `busy`=0, `tgtReady`=0, target register=0, counters=0, state=IDLE. `tgtReady` goes high on the first cycle after RESET deasserts.
- Period counter:
  - Counts 0..PERIOD_CYCLES-1 and wraps.
  - `periodTick`=1 exactly when the count equals PERIOD_CYCLES-1.
  - `dutyOut` changes only on a tick cycle (registered), so a new value is first seen by the PWM block at its count 0. The sole exception is estop.
- Handshake:
  - A transfer occurs when `tgtValid` and `tgtReady` are both high.
  - `tgtReady`=1 in all states except STOP and RESET.
  - The accepted value is clamped to [-MAX_MAG, +MAX_MAG]; for example, 31 becomes +15 and -32 becomes -15.
  - Back-to-back transfers are legal; the last accepted value wins.
- Effective target `eff` = `enable` ? target register : 0.
- Step counter:
  - Advances on each tick.
  - When it reaches STEP_PERIODS-1 on a tick, a step is taken and the counter clears.
  - It also clears on any accepted transfer while in IDLE, so the first step lands STEP_PERIODS ticks after acceptance.
- States:
  - IDLE:
    - Condition: `dutyOut` == `eff`.
    - Go to RAMP when `eff` ≠ `dutyOut`.
  - RAMP (step taken):
    - If `dutyOut` ≠ 0 and sign(`dutyOut`) ≠ sign(`eff`), or |`dutyOut`| > |`eff`|: move `dutyOut` one toward 0.
    - Otherwise: move `dutyOut` one toward `eff`.
    - If `dutyOut` becomes 0 while `eff` has the opposite sign to the pre-step value and ZERO_DWELL > 0: go to DWELL.
    - If `dutyOut` becomes equal to `eff`: go to IDLE.
  - DWELL:
    - Holds `dutyOut`=0 for ZERO_DWELL ticks, counted by its own counter, then goes to RAMP with the step counter cleared.
    - If `eff` changes to 0 or to the pre-dwell sign: leave DWELL on the next cycle, to IDLE if `eff`=0 and to RAMP otherwise.
  - STOP:
    - Entered from any state on the cycle after `estop`=1.
    - `dutyOut`=0 on that next cycle, not tick-aligned.
    - Target register cleared to 0; `tgtReady`=0.
    - When `estop`=0: go to IDLE with `dutyOut`=0.
- Simultaneous events:
  - Transfer on a step cycle: the step uses the old target; the new target applies from the next cycle.
  - estop has priority over everything except RESET.
  - RESET mid-ramp: all reset values apply on the next cycle.
- Arithmetic: all duty arithmetic is signed 6-bit. `dutyOut` never leaves [-MAX_MAG, +MAX_MAG]; -16..-32 and 16..31 are unreachable.

Optional Feature:
- Macro: PWM_RAMP_SLEW_CFG_EN.
- With PWM_RAMP_SLEW_CFG_EN:
  - Adds input port `stepPeriodsIn`, 8 bits, replacing STEP_PERIODS at run time.
  - Sampled at each step-counter clear; a value of 0 is treated as 1.
- Without PWM_RAMP_SLEW_CFG_EN: the port is absent and the STEP_PERIODS parameter is used.

Test Plan:
Bench parameters: PERIOD_CYCLES=10, STEP_PERIODS=2, ZERO_DWELL=2, MAX_MAG=15.
- Reset release, then offer +5 → accepted on the first cycle; `dutyOut` runs 1,2,3,4,5, changing every 20 clocks on tick cycles only; `busy` drops the cycle after 5 is reached.
- At +3, offer -2 → `dutyOut` 2,1,0 at 20-clock spacing; 0 held for 2 ticks (DWELL); then -1, -2; then IDLE.
- Offer 31 → target register +15; offer -32 → -15; `dutyOut` never exceeds ±15.
- At +6 mid-ramp toward +10, assert estop → `dutyOut`=0 the next cycle; `tgtReady`=0 during estop; after release, IDLE with `dutyOut`=0 and no ramp resuming.
- At +4 idle, drop `enable` → ramps 3,2,1,0; raise `enable` → ramps back to +4 with no new handshake.
- Mid-ramp at -7, assert RESET for 1 cycle → next cycle `dutyOut`=0, `busy`=0, `periodTick`=0, counters at 0 (first tick 10 clocks after release).

Source files
------------

// File: rtl/pwm_ramp_sequencer.sv
// Slew-rate-limited signed duty sequencer feeding the signed PWM generator.
// Optional macro PWM_RAMP_SLEW_CFG_EN adds run-time step rate input stepPeriodsIn.
module pwm_ramp_sequencer #(
  parameter int PERIOD_CYCLES = 1500,
  parameter int STEP_PERIODS  = 4,
  parameter int ZERO_DWELL    = 2,
  parameter int MAX_MAG       = 15
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       tgtValid,
  output logic       tgtReady,
  input  logic [5:0] tgtValue,
  input  logic       enable,
  input  logic       estop,
`ifdef PWM_RAMP_SLEW_CFG_EN
  input  logic [7:0] stepPeriodsIn,
`endif
  output logic [5:0] dutyOut,
  output logic       periodTick,
  output logic       busy
);

  localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int DW = (ZERO_DWELL > 1) ? $clog2(ZERO_DWELL) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PERIOD_CYCLES - 1);
  localparam logic [DW-1:0] DLAST = DW'((ZERO_DWELL > 0) ? ZERO_DWELL - 1 : 0);
  localparam logic signed [5:0] MAXP = 6'(MAX_MAG);
  localparam logic signed [5:0] MAXN = 6'(-MAX_MAG);

  typedef enum logic [1:0] {IDLE, RAMP, DWELL, STOP} state_t;

  state_t r_state, w_nextState;

  logic [PW-1:0]      r_periodCnt;
  logic [7:0]         r_stepCnt;
  logic [DW-1:0]      r_dwellCnt;
  logic signed [5:0]  r_duty;
  logic signed [5:0]  r_target;
  logic               r_dwellNeg;
  logic               r_readyEn;

  logic               w_tick;
  logic               w_xfer;
  logic signed [5:0]  w_tgtIn;
  logic signed [5:0]  w_clamped;
  logic signed [5:0]  w_eff;
  logic [7:0]         w_stepLast;
  logic               w_stepDue;
  logic               w_stepClr;
  logic               w_step;
  logic               w_dutyNeg;
  logic               w_effNeg;
  logic [5:0]         w_dutyMag;
  logic [5:0]         w_effMag;
  logic               w_toZero;
  logic signed [5:0]  w_stepped;
  logic               w_enterDwell;

  assign w_tick    = (r_periodCnt == PLAST);
  assign w_xfer    = tgtValid && tgtReady;
  assign w_tgtIn   = $signed(tgtValue);
  assign w_clamped = (w_tgtIn > MAXP) ? MAXP : ((w_tgtIn < MAXN) ? MAXN : w_tgtIn);
  assign w_eff     = enable ? r_target : 6'sd0;

`ifdef PWM_RAMP_SLEW_CFG_EN
  logic [7:0] r_stepLast;
  logic [7:0] w_cfgLast;

  // A programmed rate of 0 behaves as 1 (step every period).
  assign w_cfgLast  = (stepPeriodsIn == 8'd0) ? 8'd0 : stepPeriodsIn - 8'd1;
  assign w_stepLast = r_stepLast;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_stepLast <= w_cfgLast;
    end else if (w_stepClr) begin
      r_stepLast <= w_cfgLast;
    end
  end
`else
  assign w_stepLast = 8'(STEP_PERIODS - 1);
`endif

  assign w_stepDue = w_tick && (r_stepCnt == w_stepLast);
  assign w_stepClr = estop || (r_state == DWELL) || (r_state == STOP) ||
                     (w_xfer && (r_state == IDLE)) || w_stepDue;
  assign w_step    = (r_state == RAMP) && w_stepDue && (r_duty != w_eff);

  // Head toward zero first whenever the sign must flip or the magnitude shrinks.
  assign w_dutyNeg    = r_duty[5];
  assign w_effNeg     = w_eff[5];
  assign w_dutyMag    = w_dutyNeg ? -r_duty : r_duty;
  assign w_effMag     = w_effNeg ? -w_eff : w_eff;
  assign w_toZero     = ((r_duty != 6'sd0) && (w_eff != 6'sd0) && (w_dutyNeg != w_effNeg)) ||
                        (w_dutyMag > w_effMag);
  assign w_stepped    = w_toZero ? (w_dutyNeg ? r_duty + 6'sd1 : r_duty - 6'sd1)
                                 : ((w_eff > r_duty) ? r_duty + 6'sd1 : r_duty - 6'sd1);
  assign w_enterDwell = (ZERO_DWELL > 0) && (w_stepped == 6'sd0) && (w_eff != 6'sd0) &&
                        (r_duty != 6'sd0) && (w_effNeg != w_dutyNeg);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (estop) begin
      w_nextState = STOP;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_eff != r_duty) w_nextState = RAMP;
        end
        RAMP: begin
          if (r_duty == w_eff) begin
            w_nextState = IDLE;
          end else if (w_step) begin
            if (w_enterDwell)           w_nextState = DWELL;
            else if (w_stepped == w_eff) w_nextState = IDLE;
          end
        end
        DWELL: begin
          // Abandon the dwell early if the reversal is no longer wanted.
          if (w_eff == 6'sd0)                        w_nextState = IDLE;
          else if (w_effNeg == r_dwellNeg)           w_nextState = RAMP;
          else if (w_tick && (r_dwellCnt == DLAST))  w_nextState = RAMP;
        end
        STOP:    w_nextState = IDLE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (r_state != IDLE);
    tgtReady = r_readyEn && (r_state != STOP);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_periodCnt <= '0;
      r_stepCnt   <= '0;
      r_dwellCnt  <= '0;
      r_duty      <= '0;
      r_target    <= '0;
      r_dwellNeg  <= 1'b0;
      r_readyEn   <= 1'b0;
    end else begin
      r_readyEn   <= 1'b1;
      r_periodCnt <= w_tick ? '0 : r_periodCnt + PW'(1);

      if (w_stepClr)   r_stepCnt <= '0;
      else if (w_tick) r_stepCnt <= r_stepCnt + 8'd1;

      if (r_state != DWELL) r_dwellCnt <= '0;
      else if (w_tick)      r_dwellCnt <= r_dwellCnt + DW'(1);

      // estop zeroes the output immediately, bypassing tick alignment.
      if (estop) begin
        r_duty   <= '0;
        r_target <= '0;
      end else begin
        if (w_xfer) r_target <= w_clamped;
        if (w_step) begin
          r_duty <= w_stepped;
          if (w_enterDwell) r_dwellNeg <= w_dutyNeg;
        end
      end
    end
  end

  assign dutyOut    = r_duty;
  assign periodTick = w_tick;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed self-checking bench for pwm_ramp_sequencer
// (PERIOD_CYCLES=10, STEP_PERIODS=2, ZERO_DWELL=2, MAX_MAG=15).
module tb_pwm_ramp_sequencer;

  logic       CLK;
  logic       RESET;
  logic       tgtValid;
  logic       tgtReady;
  logic [5:0] tgtValue;
  logic       enable;
  logic       estop;
  logic [5:0] dutyOut;
  logic       periodTick;
  logic       busy;

  int testsRun    = 0;
  int testsFailed = 0;

  pwm_ramp_sequencer #(
    .PERIOD_CYCLES(10),
    .STEP_PERIODS (2),
    .ZERO_DWELL   (2),
    .MAX_MAG      (15)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .tgtValid  (tgtValid),
    .tgtReady  (tgtReady),
    .tgtValue  (tgtValue),
    .enable    (enable),
    .estop     (estop),
    .dutyOut   (dutyOut),
    .periodTick(periodTick),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick1();
    @(posedge CLK);
    #1;
  endtask

  // Advance until dutyOut changes; reports clocks taken and whether the
  // cycle that produced the change was a tick cycle.
  task automatic waitChange(input int limit, output int clocks,
                            output logic wasTick, output logic timedOut);
    logic [5:0] prevDuty;
    logic       prevTick;
    logic       done;
    clocks   = 0;
    wasTick  = 1'b0;
    timedOut = 1'b1;
    done     = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      prevDuty = dutyOut;
      prevTick = periodTick;
      tick1();
      clocks++;
      if (dutyOut !== prevDuty) begin
        wasTick  = prevTick;
        timedOut = 1'b0;
        done     = 1'b1;
      end
    end
  endtask

  task automatic offer(input logic [5:0] v);
    int n = 0;
    while (tgtReady !== 1'b1 && n < 50) begin
      tick1();
      n++;
    end
    testsRun++;
    if (tgtReady !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL offer_ready: tgtReady=%b want 1 within 50 clocks", tgtReady);
    end
    tgtValue = v;
    tgtValid = 1'b1;
    tick1();
    tgtValid = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) tick1();
    testsRun++;
    if (dutyOut !== 6'd0 || busy !== 1'b0 || periodTick !== 1'b0 || tgtReady !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_values: duty=%0d busy=%b tick=%b ready=%b want 0 0 0 0",
               $signed(dutyOut), busy, periodTick, tgtReady);
    end
    RESET = 1'b0;
    tick1();
    testsRun++;
    if (tgtReady !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_ready: tgtReady=%b want 1 after release", tgtReady);
    end
  endtask

  task automatic test_ramp_up();
    int clocks;
    logic wasTick, timedOut;
    offer(6'd5);
    tick1();
    testsRun++;
    if (busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL ramp_up_busy: busy=%b want 1", busy);
    end
    for (int k = 1; k <= 5; k++) begin
      waitChange(60, clocks, wasTick, timedOut);
      testsRun++;
      if (timedOut || dutyOut !== 6'(k) || wasTick !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL ramp_up_step%0d: duty=%0d onTick=%b timeout=%b want duty=%0d on tick",
                 k, $signed(dutyOut), wasTick, timedOut, k);
      end
      if (k > 1) begin
        testsRun++;
        if (clocks != 20) begin
          testsFailed++;
          $display("[TB] FAIL ramp_up_gap%0d: gap=%0d want 20", k, clocks);
        end
      end
    end
    tick1();
    testsRun++;
    if (busy !== 1'b0 || dutyOut !== 6'd5) begin
      testsFailed++;
      $display("[TB] FAIL ramp_up_done: busy=%b duty=%0d want busy=0 duty=5", busy, $signed(dutyOut));
    end
  endtask

  task automatic test_reversal();
    int clocks;
    logic wasTick, timedOut;
    int seq[5] = '{2, 1, 0, -1, -2};
    int gap[5] = '{0, 20, 20, 40, 20};
    offer(6'd3);
    for (int k = 0; k < 2; k++) begin
      waitChange(60, clocks, wasTick, timedOut);
    end
    tick1();
    testsRun++;
    if (dutyOut !== 6'd3 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reversal_setup: duty=%0d busy=%b want 3 0", $signed(dutyOut), busy);
    end
    offer(6'b111110);
    for (int k = 0; k < 5; k++) begin
      waitChange(80, clocks, wasTick, timedOut);
      testsRun++;
      if (timedOut || dutyOut !== 6'(seq[k]) || wasTick !== 1'b1 || (k > 0 && clocks != gap[k])) begin
        testsFailed++;
        $display("[TB] FAIL reversal_step%0d: duty=%0d gap=%0d onTick=%b timeout=%b want duty=%0d gap=%0d",
                 k, $signed(dutyOut), clocks, wasTick, timedOut, seq[k], gap[k]);
      end
    end
    tick1();
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reversal_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_clamp();
    int n, d, hi, lo;
    offer(6'b011111);
    tick1();
    hi = -99;
    n  = 0;
    while (busy === 1'b1 && n < 900) begin
      tick1();
      d = $signed(dutyOut);
      if (d > hi) hi = d;
      n++;
    end
    testsRun++;
    if (busy !== 1'b0 || dutyOut !== 6'd15 || hi > 15) begin
      testsFailed++;
      $display("[TB] FAIL clamp_pos: duty=%0d max=%0d busy=%b want duty=15 max<=15 busy=0",
               $signed(dutyOut), hi, busy);
    end
    repeat (60) tick1();
    testsRun++;
    if (dutyOut !== 6'd15 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL clamp_pos_hold: duty=%0d busy=%b want 15 0", $signed(dutyOut), busy);
    end
    offer(6'b100000);
    tick1();
    lo = 99;
    n  = 0;
    while (busy === 1'b1 && n < 900) begin
      tick1();
      d = $signed(dutyOut);
      if (d < lo) lo = d;
      n++;
    end
    testsRun++;
    if (busy !== 1'b0 || dutyOut !== 6'(-15) || lo < -15) begin
      testsFailed++;
      $display("[TB] FAIL clamp_neg: duty=%0d min=%0d busy=%b want duty=-15 min>=-15 busy=0",
               $signed(dutyOut), lo, busy);
    end
  endtask

  task automatic test_estop();
    int n = 0;
    offer(6'd10);
    while (dutyOut !== 6'd6 && n < 800) begin
      tick1();
      n++;
    end
    testsRun++;
    if (dutyOut !== 6'd6) begin
      testsFailed++;
      $display("[TB] FAIL estop_setup: duty=%0d want 6", $signed(dutyOut));
    end
    estop = 1'b1;
    tick1();
    testsRun++;
    if (dutyOut !== 6'd0 || tgtReady !== 1'b0 || busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL estop_hit: duty=%0d ready=%b busy=%b want 0 0 1",
               $signed(dutyOut), tgtReady, busy);
    end
    tgtValue = 6'd7;
    tgtValid = 1'b1;
    repeat (3) tick1();
    testsRun++;
    if (dutyOut !== 6'd0 || tgtReady !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL estop_hold: duty=%0d ready=%b want 0 0", $signed(dutyOut), tgtReady);
    end
    tgtValid = 1'b0;
    estop    = 1'b0;
    tick1();
    testsRun++;
    if (busy !== 1'b0 || dutyOut !== 6'd0 || tgtReady !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL estop_release: busy=%b duty=%0d ready=%b want 0 0 1",
               busy, $signed(dutyOut), tgtReady);
    end
    repeat (60) tick1();
    testsRun++;
    if (busy !== 1'b0 || dutyOut !== 6'd0) begin
      testsFailed++;
      $display("[TB] FAIL estop_no_resume: busy=%b duty=%0d want 0 0", busy, $signed(dutyOut));
    end
  endtask

  task automatic test_enable();
    int n, clocks;
    logic wasTick, timedOut;
    int down[4] = '{3, 2, 1, 0};
    int up[4]   = '{1, 2, 3, 4};
    offer(6'd4);
    tick1();
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick1();
      n++;
    end
    testsRun++;
    if (dutyOut !== 6'd4 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL enable_setup: duty=%0d busy=%b want 4 0", $signed(dutyOut), busy);
    end
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      waitChange(60, clocks, wasTick, timedOut);
      testsRun++;
      if (timedOut || dutyOut !== 6'(down[k]) || wasTick !== 1'b1 || (k > 0 && clocks != 20)) begin
        testsFailed++;
        $display("[TB] FAIL enable_down%0d: duty=%0d gap=%0d onTick=%b timeout=%b want duty=%0d",
                 k, $signed(dutyOut), clocks, wasTick, timedOut, down[k]);
      end
    end
    tick1();
    enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      waitChange(60, clocks, wasTick, timedOut);
      testsRun++;
      if (timedOut || dutyOut !== 6'(up[k]) || wasTick !== 1'b1 || (k > 0 && clocks != 20)) begin
        testsFailed++;
        $display("[TB] FAIL enable_up%0d: duty=%0d gap=%0d onTick=%b timeout=%b want duty=%0d",
                 k, $signed(dutyOut), clocks, wasTick, timedOut, up[k]);
      end
    end
    tick1();
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL enable_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_ramp();
    int n = 0;
    offer(6'b110110);
    while (dutyOut !== 6'(-7) && n < 600) begin
      tick1();
      n++;
    end
    testsRun++;
    if (dutyOut !== 6'(-7) || busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL rst_mid_setup: duty=%0d busy=%b want -7 1", $signed(dutyOut), busy);
    end
    RESET = 1'b1;
    tick1();
    testsRun++;
    if (dutyOut !== 6'd0 || busy !== 1'b0 || periodTick !== 1'b0 || tgtReady !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rst_mid_values: duty=%0d busy=%b tick=%b ready=%b want 0 0 0 0",
               $signed(dutyOut), busy, periodTick, tgtReady);
    end
    RESET = 1'b0;
    n = 0;
    while (periodTick !== 1'b1 && n < 30) begin
      tick1();
      n++;
    end
    testsRun++;
    if (n != 9) begin
      testsFailed++;
      $display("[TB] FAIL rst_mid_first_tick: edges after reset=%0d want 9 (10th cycle)", n);
    end
    tick1();
    testsRun++;
    if (periodTick !== 1'b0 || tgtReady !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL rst_mid_tick_pulse: tick=%b ready=%b want 0 1", periodTick, tgtReady);
    end
    repeat (30) tick1();
    testsRun++;
    if (dutyOut !== 6'd0 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rst_mid_no_resume: duty=%0d busy=%b want 0 0", $signed(dutyOut), busy);
    end
  endtask

  initial begin
    RESET    = 1'b1;
    tgtValid = 1'b0;
    tgtValue = 6'd0;
    enable   = 1'b1;
    estop    = 1'b0;
    test_reset();
    test_ramp_up();
    test_reversal();
    test_clamp();
    test_estop();
    test_enable();
    test_reset_mid_ramp();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
